// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the MIPS pipeline datapath and the stall/flush sequencer.
// The datapath (master) reports ID/EX status; the controller (slave) drives enables.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        uses_rs_id;
  logic        uses_rt_id;
  logic        halt_id;
  logic [4:0]  outReg_ex;
  logic        memread_ex;
  logic        nop_ex;
  logic        branch_taken_ex;
  logic        dmem_busy;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        pipe_freeze;
  logic        halted;
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [1:0]  state;

  modport master (
    output rs_id, rt_id, uses_rs_id, uses_rt_id, halt_id,
           outReg_ex, memread_ex, nop_ex, branch_taken_ex, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
           halted, mem_timeout, stall_cycles, state
  );

  modport slave (
    input  rs_id, rt_id, uses_rs_id, uses_rt_id, halt_id,
           outReg_ex, memread_ex, nop_ex, branch_taken_ex, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
           halted, mem_timeout, stall_cycles, state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, memory freeze,
// branch flush, halt drain, plus a saturating stall counter and a sticky memory timeout.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipeline_hazard_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_DRAIN      = 2'd2,
    ST_HALTED     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_q, stall_d;

  logic hazard;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, halted;

  // Register zero never carries a real dependency, so it cannot cause a load-use stall.
  assign hazard = bus.memread_ex & ~bus.nop_ex & (bus.outReg_ex != 5'd0) &
                  ((bus.uses_rs_id & (bus.outReg_ex == bus.rs_id)) |
                   (bus.uses_rt_id & (bus.outReg_ex == bus.rt_id)));

  always_comb begin
    // NOTE: every output and next-state term is defaulted first so no path infers a latch.
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_RUN, ST_LOAD_STALL: begin
        if (bus.dmem_busy) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          pipe_freeze = 1'b1;
        end else if (bus.branch_taken_ex) begin
          // The stalled ID instruction is squashed, so any pending bubbles are dropped.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = ST_RUN;
          cnt_d       = '0;
        end else if (state_q == ST_LOAD_STALL) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else if (hazard) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d = ST_LOAD_STALL;
            cnt_d   = 4'(LOAD_BUBBLES - 1);
          end
        end else if (bus.halt_id) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = ST_DRAIN;
          cnt_d       = 4'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        pipe_freeze = bus.dmem_busy;
        if (!bus.dmem_busy) begin
          if (cnt_q == 4'd1) begin
            state_d = ST_HALTED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      ST_HALTED: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: ;
    endcase

    // Hold the front end and keep injecting nops while reset is asserted.
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      pipe_freeze = 1'b0;
      halted      = 1'b0;
    end
  end

  always_comb begin
    busy_d    = '0;
    timeout_d = timeout_q;
    stall_d   = stall_q;
    if (bus.dmem_busy) begin
      busy_d = (busy_q == 8'hFF) ? busy_q : busy_q + 8'd1;
      if (busy_d >= 8'(MEM_TIMEOUT)) timeout_d = 1'b1;
    end
    if ((state_q == ST_RUN || state_q == ST_LOAD_STALL) && !pc_write && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      busy_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.pipe_freeze  = pipe_freeze;
  assign bus.halted       = halted;
  assign bus.mem_timeout  = timeout_q;
  assign bus.stall_cycles = stall_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LOAD_BUBBLES=1 and 3) share stimulus;
// table vectors, directed corner sequences and random cycles against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int LB_A = 1;
  localparam int LB_B = 3;
  localparam int DC   = 3;
  localparam int MT   = 4;

  localparam int M_RUN = 0;
  localparam int M_LST = 1;
  localparam int M_DRN = 2;
  localparam int M_HLT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs_id, rt_id, out_reg_ex;
  logic uses_rs_id, uses_rt_id, halt_id, memread_ex, nop_ex, branch_taken_ex, dmem_busy;

  pipeline_hazard_ctrl_if ifa ();
  pipeline_hazard_ctrl_if ifb ();

  assign ifa.rs_id = rs_id;                     assign ifb.rs_id = rs_id;
  assign ifa.rt_id = rt_id;                     assign ifb.rt_id = rt_id;
  assign ifa.uses_rs_id = uses_rs_id;           assign ifb.uses_rs_id = uses_rs_id;
  assign ifa.uses_rt_id = uses_rt_id;           assign ifb.uses_rt_id = uses_rt_id;
  assign ifa.halt_id = halt_id;                 assign ifb.halt_id = halt_id;
  assign ifa.outReg_ex = out_reg_ex;            assign ifb.outReg_ex = out_reg_ex;
  assign ifa.memread_ex = memread_ex;           assign ifb.memread_ex = memread_ex;
  assign ifa.nop_ex = nop_ex;                   assign ifb.nop_ex = nop_ex;
  assign ifa.branch_taken_ex = branch_taken_ex; assign ifb.branch_taken_ex = branch_taken_ex;
  assign ifa.dmem_busy = dmem_busy;             assign ifb.dmem_busy = dmem_busy;

  pipeline_hazard_ctrl #(.LOAD_BUBBLES(LB_A), .DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT))
    u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  pipeline_hazard_ctrl #(.LOAD_BUBBLES(LB_B), .DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  wire [24:0] got_a = {ifa.pc_write, ifa.ifid_write, ifa.ifid_flush, ifa.idex_bubble,
                       ifa.pipe_freeze, ifa.halted, ifa.mem_timeout, ifa.stall_cycles, ifa.state};
  wire [24:0] got_b = {ifb.pc_write, ifb.ifid_write, ifb.ifid_flush, ifb.idex_bubble,
                       ifb.pipe_freeze, ifb.halted, ifb.mem_timeout, ifb.stall_cycles, ifb.state};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: mode, remaining stall/drain cycles, busy run length, sticky timeout.
  typedef struct {
    int mode;
    int rem;
    int busy;
    bit tmo;
    int stalls;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = M_RUN; m.rem = 0; m.busy = 0; m.tmo = 1'b0; m.stalls = 0;
    return m;
  endfunction

  function automatic void model(input int lb, input mdl_t m, output logic [24:0] o, output mdl_t n);
    logic pc, ifid, fl, bub, frz, hlt;
    bit hz;
    hz = memread_ex && !nop_ex && out_reg_ex != 0 &&
         ((uses_rs_id && out_reg_ex == rs_id) || (uses_rt_id && out_reg_ex == rt_id));
    n = m;
    pc = 1; ifid = 1; fl = 0; bub = 0; frz = 0; hlt = 0;
    if (m.mode == M_HLT) begin
      pc = 0; ifid = 0; bub = 1; hlt = 1;
    end else if (m.mode == M_DRN) begin
      pc = 0; ifid = 0; bub = 1; frz = dmem_busy;
      if (!dmem_busy) begin
        n.rem = m.rem - 1;
        if (n.rem == 0) n.mode = M_HLT;
      end
    end else if (dmem_busy) begin
      pc = 0; ifid = 0; frz = 1;
    end else if (branch_taken_ex) begin
      fl = 1; bub = 1; n.mode = M_RUN; n.rem = 0;
    end else if (m.mode == M_LST || hz) begin
      pc = 0; ifid = 0; bub = 1;
      if (m.mode == M_LST) begin
        n.rem = m.rem - 1;
        if (n.rem == 0) n.mode = M_RUN;
      end else if (lb > 1) begin
        n.mode = M_LST; n.rem = lb - 1;
      end
    end else if (halt_id) begin
      pc = 0; ifid = 0; bub = 1; n.mode = M_DRN; n.rem = DC;
    end
    if ((m.mode == M_RUN || m.mode == M_LST) && !pc && m.stalls < 65535) n.stalls = m.stalls + 1;
    n.busy = dmem_busy ? ((m.busy < 255) ? m.busy + 1 : 255) : 0;
    if (dmem_busy && n.busy >= MT) n.tmo = 1'b1;
    o = {pc, ifid, fl, bub, frz, hlt, m.tmo, 16'(m.stalls), 2'(m.mode)};
    if (!rst_n) begin
      o = {6'b000100, 1'b0, 16'd0, 2'd0};
      n = mdl_reset();
    end
  endfunction

  // One clock: compare both DUTs with the model on the falling edge, advance on the rising edge.
  task automatic cycle(input string tag);
    logic [24:0] oa, ob;
    mdl_t na, nb;
    @(negedge clk);
    model(LB_A, ma, oa, na);
    model(LB_B, mb, ob, nb);
    check({tag, "/A"}, 32'(got_a), 32'(oa));
    check({tag, "/B"}, 32'(got_b), 32'(ob));
    @(posedge clk);
    ma = na;
    mb = nb;
    #1;
  endtask

  task automatic idle();
    rs_id = 0; rt_id = 0; out_reg_ex = 0;
    uses_rs_id = 0; uses_rt_id = 0; halt_id = 0;
    memread_ex = 0; nop_ex = 0; branch_taken_ex = 0; dmem_busy = 0;
  endtask

  task automatic load_use(input logic [4:0] dst);
    memread_ex = 1; out_reg_ex = dst; rt_id = dst; uses_rt_id = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       memread, nop;
    logic [4:0] outr, rs, rt;
    logic       urs, urt, halt, br, busy;
    logic [4:0] exp;     // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
    logic [1:0] exp_st;  // state of the LOAD_BUBBLES=1 instance after the edge
  } vec_t;

  vec_t vt[11];

  initial begin
    int bub_cnt, frz_cnt, pc0_cnt, drain_cnt;

    vt[0]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 2'd0};
    vt[1]  = '{1'b1, 1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010, 2'd0};
    vt[2]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, 2'd0};
    vt[3]  = '{1'b1, 1'b0, 5'd7, 5'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00010, 2'd0};
    vt[4]  = '{1'b1, 1'b0, 5'd7, 5'd7, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, 2'd0};
    vt[5]  = '{1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, 2'd0};
    vt[6]  = '{1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, 2'd0};
    vt[7]  = '{1'b1, 1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b11110, 2'd0};
    vt[8]  = '{1'b1, 1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'b00001, 2'd0};
    vt[9]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00010, 2'd2};
    vt[10] = '{1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00010, 2'd0};

    idle();
    ma = mdl_reset();
    mb = mdl_reset();
    #3;
    check("reset_pc_write", 32'(ifa.pc_write), 32'd0);
    check("reset_ifid_write", 32'(ifa.ifid_write), 32'd0);
    check("reset_idex_bubble", 32'(ifa.idex_bubble), 32'd1);
    check("reset_state", 32'(ifb.state), 32'd0);
    check("reset_stall_cycles", 32'(ifb.stall_cycles), 32'd0);
    do_reset();

    // Single-cycle decisions from a fresh RUN state.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      memread_ex = vt[i].memread; nop_ex = vt[i].nop; out_reg_ex = vt[i].outr;
      rs_id = vt[i].rs; rt_id = vt[i].rt; uses_rs_id = vt[i].urs; uses_rt_id = vt[i].urt;
      halt_id = vt[i].halt; branch_taken_ex = vt[i].br; dmem_busy = vt[i].busy;
      @(negedge clk);
      check($sformatf("vec%0d_ctrl", i),
            32'({ifa.pc_write, ifa.ifid_write, ifa.ifid_flush, ifa.idex_bubble, ifa.pipe_freeze}),
            32'(vt[i].exp));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_state", i), 32'(ifa.state), 32'(vt[i].exp_st));
    end
    idle();

    // Load-use with one bubble stalls exactly one cycle; r0 destination never stalls.
    do_reset();
    pc0_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      idle();
      if (k == 0) load_use(5'd5);
      #2;
      if (!ifa.pc_write && !ifa.ifid_write && ifa.idex_bubble) pc0_cnt++;
      cycle("lu1");
    end
    check("lu1_stall_count", 32'(pc0_cnt), 32'd1);
    pc0_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      idle();
      load_use(5'd0);
      #2;
      if (!ifa.pc_write) pc0_cnt++;
      cycle("lu_r0");
    end
    check("lu_r0_stall_count", 32'(pc0_cnt), 32'd0);

    // Three bubbles with a memory freeze landing on the second one.
    idle();
    do_reset();
    bub_cnt = 0;
    frz_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k == 0) load_use(5'd5); else nop_ex = 1;
      dmem_busy = (k == 1);
      #2;
      if (!ifb.pc_write && ifb.idex_bubble && !ifb.pipe_freeze) bub_cnt++;
      if (!ifb.pc_write && ifb.pipe_freeze && !ifb.idex_bubble) frz_cnt++;
      cycle("lb3");
    end
    check("lb3_bubbles", 32'(bub_cnt), 32'd3);
    check("lb3_frozen", 32'(frz_cnt), 32'd1);
    check("lb3_stall_cycles", 32'(ifb.stall_cycles), 32'd4);
    check("lb3_state", 32'(ifb.state), 32'd0);
    check("lb1_stall_cycles", 32'(ifa.stall_cycles), 32'd2);

    // Halt: three drain cycles, then HALTED ignores branches and hazards.
    idle();
    do_reset();
    halt_id = 1;
    cycle("halt");
    idle();
    drain_cnt = 0;
    for (int k = 0; k < DC; k++) begin
      #2;
      if (ifa.state == 2'd2 && ifa.idex_bubble && !ifa.pc_write) drain_cnt++;
      cycle("drain");
    end
    check("drain_cycles", 32'(drain_cnt), 32'(DC));
    check("halted_state", 32'(ifa.state), 32'd3);
    check("halted_flag", 32'(ifa.halted), 32'd1);
    for (int k = 0; k < 3; k++) begin
      idle();
      load_use(5'd6);
      branch_taken_ex = 1;
      #2;
      check("halted_no_flush", 32'(ifa.ifid_flush), 32'd0);
      check("halted_no_pc", 32'(ifb.pc_write), 32'd0);
      cycle("halted");
      check("halted_stays", 32'(ifb.state), 32'd3);
    end

    // Memory timeout: three busy cycles stay below, six cross it and the flag sticks.
    idle();
    do_reset();
    dmem_busy = 1;
    repeat (3) cycle("busy3");
    dmem_busy = 0;
    cycle("busy3_idle");
    check("timeout_short", 32'(ifa.mem_timeout), 32'd0);
    dmem_busy = 1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("timeout_edge%0d", k), 32'(ifa.mem_timeout), 32'(k >= 4));
      cycle("busy6");
    end
    dmem_busy = 0;
    cycle("busy6_idle");
    check("timeout_sticky", 32'(ifb.mem_timeout), 32'd1);

    // Asynchronous reset in the middle of a LOAD_STALL run.
    idle();
    do_reset();
    load_use(5'd5);
    cycle("pre_rst");
    idle();
    check("mid_lst_state", 32'(ifb.state), 32'd1);
    #2;
    rst_n = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
    #1;
    check("async_rst_state", 32'(ifb.state), 32'd0);
    check("async_rst_pc", 32'(ifb.pc_write), 32'd0);
    check("async_rst_bubble", 32'(ifb.idex_bubble), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_pc", 32'(ifb.pc_write), 32'd1);
    check("post_rst_stalls", 32'(ifb.stall_cycles), 32'd0);
    cycle("post_rst");

    // Random traffic against the model, with periodic resets so halts do not dominate.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        idle();
        do_reset();
      end
      rs_id = 5'($urandom_range(0, 3));
      rt_id = 5'($urandom_range(0, 3));
      out_reg_ex = 5'($urandom_range(0, 3));
      uses_rs_id = 1'($urandom_range(0, 1));
      uses_rt_id = 1'($urandom_range(0, 1));
      memread_ex = ($urandom_range(0, 9) < 4);
      nop_ex = ($urandom_range(0, 9) < 2);
      branch_taken_ex = ($urandom_range(0, 9) == 0);
      dmem_busy = ($urandom_range(0, 9) < 2);
      halt_id = ($urandom_range(0, 99) < 2);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It detects load-use hazards that MEM-stage forwarding cannot cover, freezes the pipeline while data memory is busy, flushes on taken branches, and drains the pipeline on a halt instruction. It drives the write enables of the PC and of every pipeline register, and keeps a saturating stall-cycle counter and a memory-timeout flag.

Parameters:
LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (1..15)
DRAIN_CYCLES, 3, cycles spent draining after a halt is accepted (1..15)
MEM_TIMEOUT, 64, consecutive dmem_busy cycles before mem_timeout sets (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs_id  in  5  rs of instruction in ID
rt_id  in  5  rt of instruction in ID
uses_rs_id  in  1  ID instruction reads rs
uses_rt_id  in  1  ID instruction reads rt
halt_id  in  1  ID holds a halt instruction
outReg_ex  in  5  destination register of EX instruction
memread_ex  in  1  EX instruction is a load
nop_ex  in  1  EX holds a bubble
branch_taken_ex  in  1  branch in EX resolved taken
dmem_busy  in  1  data memory not ready this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  clear IF/ID to nop
idex_bubble  out  1  load nop into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
halted  out  1  core halted
mem_timeout  out  1  sticky memory-timeout error
stall_cycles  out  16  saturating stall count
state  out  2  0 RUN, 1 LOAD_STALL, 2 DRAIN, 3 HALTED

Behaviour:
- Reset (rst_n=0, asynchronous): state=RUN, bubble counter=0, drain counter=0, busy counter=0, mem_timeout=0, stall_cycles=0. While rst_n=0 the outputs are forced: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, pipe_freeze=0, halted=0.
- Control outputs are combinational from the state, the counters and the inputs. They apply in the same cycle.
- hazard = memread_ex & ~nop_ex & (outReg_ex!=0) & ((uses_rs_id & outReg_ex==rs_id) | (uses_rt_id & outReg_ex==rt_id)).
- Defaults: pc_write=1, ifid_write=1, all other outputs 0.
- Priority in RUN and LOAD_STALL: dmem_busy > branch_taken_ex > hazard/LOAD_STALL > halt_id.
  - dmem_busy=1: pc_write=0, ifid_write=0, pipe_freeze=1, idex_bubble=0. State and counters (except the busy counter) hold.
  - RUN with branch_taken_ex: ifid_flush=1, idex_bubble=1, pc_write=1. Any hazard and halt_id are ignored because that ID instruction is squashed.
  - RUN with hazard: pc_write=0, ifid_write=0, idex_bubble=1. If LOAD_BUBBLES>1, go to LOAD_STALL with counter=LOAD_BUBBLES-1.
  - LOAD_STALL: same outputs as a hazard cycle. The counter decrements each unfrozen cycle. Go to RUN in the cycle the counter equals 1.
  - RUN with halt_id and nothing of higher priority: pc_write=0, ifid_write=0, idex_bubble=1. Go to DRAIN with counter=DRAIN_CYCLES.
- DRAIN:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - dmem_busy still freezes the pipeline (pipe_freeze=1) and the counter holds while frozen.
  - branch_taken_ex and hazard are ignored.
  - Go to HALTED when the counter reaches 1 in an unfrozen cycle.
- HALTED: pc_write=0, ifid_write=0, idex_bubble=1, halted=1. Exit only by reset.
- Busy counter (8 bits):
  - Increments while dmem_busy=1 and clears when dmem_busy=0.
  - When the busy counter reaches MEM_TIMEOUT while dmem_busy=1, mem_timeout=1 (registered). It stays set until reset.
  - The busy counter saturates at 255.
- stall_cycles increments by 1 on each clock edge where pc_write=0 and state is RUN or LOAD_STALL. It saturates at 16'hFFFF and never wraps.

Test Plan:
- Reset mid-LOAD_STALL (LOAD_BUBBLES=3): drop rst_n asynchronously -> state=0, pc_write=0, idex_bubble=1 immediately. After release, pc_write=1 and stall_cycles=0.
- Load-use: memread_ex=1, outReg_ex=5, rt_id=5, uses_rt_id=1 -> exactly 1 cycle with pc_write=0, ifid_write=0, idex_bubble=1. Repeat with outReg_ex=0 -> no stall.
- LOAD_BUBBLES=3 with dmem_busy=1 in the second bubble -> 3 bubble cycles plus 1 frozen cycle (pipe_freeze=1, idex_bubble=0). stall_cycles increases by 4.
- Branch and hazard together: branch_taken_ex=1 with the hazard condition true and halt_id=1 -> ifid_flush=1, idex_bubble=1, pc_write=1, state stays RUN.
- Halt: halt_id=1 in RUN -> DRAIN for 3 cycles, then state=3 and halted=1. Further branch_taken_ex or hazard inputs cause no change.
- Timeout (MEM_TIMEOUT=4): dmem_busy held for 6 cycles -> mem_timeout rises after the 4th busy edge and stays 1 after dmem_busy falls. dmem_busy held for 3 cycles -> mem_timeout stays 0.
